// File: rtl/cpu5_lsu.sv
// Load/store unit for the CPU5 datapath: runs one word-sized req/gnt/rvalid
// transaction on the data bus per memory instruction and stalls the core meanwhile.
module cpu5_lsu #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            memread,
    input  logic            memwrite,
    input  logic [XLEN-1:0] addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata,
    output logic            stall,
    output logic            fault,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [XLEN-1:0] bus_wdata,
    output logic [3:0]      bus_be,
    input  logic            bus_gnt,
    input  logic            bus_rvalid,
    input  logic [XLEN-1:0] bus_rdata,
    input  logic            bus_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            access;

    assign access = memread | memwrite;
    assign bus_be = 4'hF;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        stall     = 1'b0;
        fault     = 1'b0;
        bus_req   = 1'b0;
        bus_we    = we_q;
        bus_addr  = addr_q;
        bus_wdata = wdata_q;
        rdata     = '0;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    if (addr[1:0] != 2'b00) begin
                        fault = 1'b1;
                    end else begin
                        // Launch cycle drives the bus straight from the datapath
                        // so a same-cycle grant loses no time.
                        stall     = 1'b1;
                        bus_req   = 1'b1;
                        bus_we    = memwrite;
                        bus_addr  = {addr[XLEN-1:2], 2'b00};
                        bus_wdata = wdata;
                        we_d      = memwrite;
                        addr_d    = {addr[XLEN-1:2], 2'b00};
                        wdata_d   = wdata;
                        state_d   = bus_gnt ? RESP : REQ;
                    end
                end
            end
            REQ: begin
                stall   = 1'b1;
                bus_req = 1'b1;
                if (bus_gnt) state_d = RESP;
            end
            RESP: begin
                stall = 1'b1;
                cnt_d = cnt_q + 8'd1;
                if (bus_rvalid) begin
                    fault   = bus_err;
                    rdata_d = (bus_err || we_q) ? '0 : bus_rdata;
                    cnt_d   = '0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    fault   = 1'b1;
                    rdata_d = '0;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                rdata   = rdata_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_cpu5_lsu.sv
// Directed bench for cpu5_lsu; inputs change 1ns after the rising edge and
// outputs are checked 1ns later, well away from the next edge.
module tb_cpu5_lsu;

    logic        clk = 1'b0;
    logic        reset, memread, memwrite;
    logic [31:0] addr, wdata, rdata;
    logic        stall, fault, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt, bus_rvalid, bus_err;
    logic [31:0] bus_rdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu5_lsu #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
        .addr(addr), .wdata(wdata), .rdata(rdata), .stall(stall), .fault(fault),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_gnt(bus_gnt),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1; memread = 0; memwrite = 0; addr = 0; wdata = 0;
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0; bus_err = 0;
        tick; tick;
        reset = 0; #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall); end
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got %b want 0", fault); end
        n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", bus_req); end
        n_cmp++; if (bus_we !== 1'b0) begin n_err++; $display("FAIL reset_we got %b want 0", bus_we); end
        n_cmp++; if (bus_addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got %h want 0", bus_addr); end
        n_cmp++; if (bus_wdata !== 32'h0) begin n_err++; $display("FAIL reset_wdata got %h want 0", bus_wdata); end
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata got %h want 0", rdata); end
    endtask

    task automatic test_load;
        int stall_cycles = 0;
        tick;
        memread = 1; addr = 32'h0000_1004; bus_gnt = 1; #1;
        n_cmp++; if (bus_req !== 1'b1) begin n_err++; $display("FAIL load_req got %b want 1", bus_req); end
        n_cmp++; if (bus_addr !== 32'h0000_1004) begin n_err++; $display("FAIL load_addr got %h want 00001004", bus_addr); end
        n_cmp++; if (bus_we !== 1'b0) begin n_err++; $display("FAIL load_we got %b want 0", bus_we); end
        n_cmp++; if (bus_be !== 4'hF) begin n_err++; $display("FAIL load_be got %h want f", bus_be); end
        if (stall) stall_cycles++;
        tick; bus_gnt = 0; #1;
        n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL load_resp_req got %b want 0", bus_req); end
        if (stall) stall_cycles++;
        tick; bus_rvalid = 1; bus_rdata = 32'hDEAD_BEEF; #1;
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL load_fault got %b want 0", fault); end
        if (stall) stall_cycles++;
        tick; bus_rvalid = 0; bus_rdata = 0; #1;
        n_cmp++; if (stall_cycles != 3) begin n_err++; $display("FAIL load_stall_cycles got %0d want 3", stall_cycles); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL load_done_stall got %b want 0", stall); end
        n_cmp++; if (rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL load_done_rdata got %h want deadbeef", rdata); end
        tick; memread = 0; #1;
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL load_idle_rdata got %h want 0", rdata); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL load_idle_stall got %b want 0", stall); end
    endtask

    task automatic test_store;
        int req_cycles = 0;
        tick;
        memwrite = 1; addr = 32'h0000_2000; wdata = 32'h1234_5678;
        for (int i = 0; i < 4; i++) begin
            bus_gnt = (i == 3); #1;
            if (bus_req) req_cycles++;
            n_cmp++; if (bus_addr !== 32'h0000_2000) begin n_err++; $display("FAIL store_addr[%0d] got %h want 00002000", i, bus_addr); end
            n_cmp++; if (bus_wdata !== 32'h1234_5678) begin n_err++; $display("FAIL store_wdata[%0d] got %h want 12345678", i, bus_wdata); end
            n_cmp++; if (bus_we !== 1'b1) begin n_err++; $display("FAIL store_we[%0d] got %b want 1", i, bus_we); end
            n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL store_stall[%0d] got %b want 1", i, stall); end
            tick;
            // Datapath inputs wander after launch; bus must keep the held values.
            addr = 32'hFFFF_FFF0; wdata = 32'h0;
        end
        bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'hAAAA_5555; #1;
        if (bus_req) req_cycles++;
        tick; bus_rvalid = 0; bus_rdata = 0; #1;
        if (bus_req) req_cycles++;
        n_cmp++; if (req_cycles != 4) begin n_err++; $display("FAIL store_req_cycles got %0d want 4", req_cycles); end
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL store_done_rdata got %h want 0", rdata); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL store_done_stall got %b want 0", stall); end
        tick; memwrite = 0; addr = 0; #1;
        n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL store_idle_req got %b want 0", bus_req); end
    endtask

    task automatic test_misaligned;
        tick;
        memread = 1; addr = 32'h0000_1002; bus_gnt = 1; #1;
        n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL mis_fault got %b want 1", fault); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL mis_stall got %b want 0", stall); end
        n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL mis_req got %b want 0", bus_req); end
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL mis_rdata got %h want 0", rdata); end
        tick; memread = 0; bus_gnt = 0; #1;
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL mis_next_fault got %b want 0", fault); end
        n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL mis_next_req got %b want 0", bus_req); end
    endtask

    task automatic test_bus_err;
        tick;
        memread = 1; addr = 32'h0000_3000; bus_gnt = 1; #1;
        tick; bus_gnt = 0; bus_rvalid = 1; bus_err = 1; bus_rdata = 32'h5A5A_5A5A; #1;
        n_cmp++; if (fault !== 1'b1) begin n_err++; $display("FAIL err_fault got %b want 1", fault); end
        n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL err_stall got %b want 1", stall); end
        tick; bus_rvalid = 0; bus_err = 0; bus_rdata = 0; #1;
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL err_done_rdata got %h want 0", rdata); end
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL err_done_fault got %b want 0", fault); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL err_done_stall got %b want 0", stall); end
        tick; memread = 0; #1;
    endtask

    task automatic test_timeout;
        tick;
        memread = 1; addr = 32'h0000_4008; bus_gnt = 1; #1;
        tick; bus_gnt = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (fault !== (i == 3)) begin n_err++; $display("FAIL to_fault[%0d] got %b want %b", i, fault, (i == 3)); end
            n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL to_stall[%0d] got %b want 1", i, stall); end
            tick;
        end
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL to_done_stall got %b want 0", stall); end
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL to_done_rdata got %h want 0", rdata); end
        tick; memread = 0;
        repeat (10) tick;
        bus_rvalid = 1; bus_err = 1; bus_rdata = 32'h1111_2222; #1;
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL to_late_fault got %b want 0", fault); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL to_late_stall got %b want 0", stall); end
        tick; bus_rvalid = 0; bus_err = 0; bus_rdata = 0; #1;
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL to_late_rdata got %h want 0", rdata); end
    endtask

    task automatic test_reset_mid;
        tick;
        memread = 1; addr = 32'h0000_5000; bus_gnt = 1; #1;
        tick; bus_gnt = 0; reset = 1; #1;
        tick; reset = 0; memread = 0; #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_mid_stall got %b want 0", stall); end
        n_cmp++; if (bus_req !== 1'b0) begin n_err++; $display("FAIL rst_mid_req got %b want 0", bus_req); end
        bus_rvalid = 1; bus_rdata = 32'h7777_7777; #1;
        n_cmp++; if (fault !== 1'b0) begin n_err++; $display("FAIL rst_late_fault got %b want 0", fault); end
        tick; bus_rvalid = 0; bus_rdata = 0; #1;
        n_cmp++; if (rdata !== 32'h0) begin n_err++; $display("FAIL rst_late_rdata got %h want 0", rdata); end
        memread = 1; addr = 32'h0000_6000; bus_gnt = 1; #1;
        n_cmp++; if (bus_req !== 1'b1) begin n_err++; $display("FAIL rst_new_req got %b want 1", bus_req); end
        tick; bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'hCAFE_F00D; #1;
        tick; bus_rvalid = 0; bus_rdata = 0; #1;
        n_cmp++; if (rdata !== 32'hCAFE_F00D) begin n_err++; $display("FAIL rst_new_rdata got %h want cafef00d", rdata); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL rst_new_stall got %b want 0", stall); end
        tick; memread = 0; #1;
    endtask

    initial begin
        test_reset;
        test_load;
        test_store;
        test_misaligned;
        test_bus_err;
        test_timeout;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
